tb_mem_arbiter: RTL and testbench
=================================

TB_MEM_ARBITER -- requirements
Module: tb_mem_arbiter

Interface
REQ-001 SHALL have parameter NrPorts, default 3, number of requester ports (cores plus debug system-bus port), range 2..8.
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width; byte-enable width BeWidth = DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 2, accepted-but-unanswered transaction limit, range 1..8.
REQ-005 SHALL have port clk_i  in  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-006 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports req_i / we_i  in  NrPorts  per-port request / write strobe.
REQ-008 SHALL have ports addr_i  in  NrPorts x AddrWidth, wdata_i  in  NrPorts x DataWidth, be_i  in  NrPorts x BeWidth: per-port request fields.
REQ-009 SHALL have ports gnt_o / rvalid_o  out  NrPorts  per-port grant / response valid.
REQ-010 SHALL have port rdata_o  out  DataWidth  response data, shared by all ports.
REQ-011 SHALL have ports mreq_o, mwe_o  out  1; maddr_o  out  AddrWidth; mwdata_o  out  DataWidth; mbe_o  out  BeWidth: target request.
REQ-012 SHALL have ports mgnt_i, mrvalid_i  in  1; mrdata_i  in  DataWidth: target grant / response.
REQ-013 SHALL have ports idle_o  out  1, no pending work; err_o  out  1, sticky protocol error.

Function
REQ-014 SHALL assert mreq_o when any req_i bit is set and occupancy < MaxOutstanding; mreq_o SHALL be low when occupancy == MaxOutstanding, even if mrvalid_i pops in that cycle.
REQ-015 SHALL select the winner round-robin: search starts at port (last_granted+1) mod NrPorts; last_granted is port NrPorts-1 after reset, so port 0 has first priority.
REQ-016 SHALL drive maddr_o/mwe_o/mbe_o/mwdata_o from the selected port combinationally; outputs are zero when mreq_o is low.
REQ-017 SHALL lock the selection while mreq_o && !mgnt_i: no re-arbitration until the transaction is granted or the locked port drops req_i.
REQ-018 SHALL assert gnt_o[k] combinationally in the cycle mreq_o && mgnt_i && selected port == k; at most one gnt_o bit is set per cycle.
REQ-019 SHALL push the granted port ID into an in-order ID FIFO of depth MaxOutstanding on each accepted transfer, and update last_granted.
REQ-020 SHALL, on mrvalid_i with a non-empty FIFO, pop the head ID, assert rvalid_o[id] in the same cycle, and pass mrdata_i to rdata_o.
REQ-021 SHALL support push and pop in the same cycle; occupancy is then unchanged.
REQ-022 SHALL ignore mrvalid_i when the FIFO is empty: no rvalid_o bit is asserted, and err_o is set at the next clock edge and held until reset.
REQ-023 SHALL drive idle_o = (occupancy == 0) && (req_i == 0).
REQ-024 SHALL keep the occupancy counter $clog2(MaxOutstanding+1) bits wide, and FIFO read/write pointers SHALL wrap modulo MaxOutstanding.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously clear the FIFO, occupancy, lock and err_o, and set last_granted to NrPorts-1.
REQ-026 SHALL hold all outputs at 0 during reset, except idle_o = (req_i == 0).
REQ-027 SHALL discard in-flight transactions on reset mid-operation; a stale mrvalid_i after reset SHALL set err_o per REQ-022.

Configuration
REQ-028 SHALL, with macro TB_MEM_ARB_FIXED_PRIO_EN defined, give port NrPorts-1 (debug system-bus port) absolute priority whenever it requests; ports 0..NrPorts-2 are arbitrated round-robin among themselves.
REQ-029 SHALL, without TB_MEM_ARB_FIXED_PRIO_EN, apply pure round-robin across all NrPorts ports.

Verification
REQ-030 SHALL cover: NrPorts=3, all req_i=3'b111 held, mgnt_i=1, mrvalid_i one cycle after each grant -> grants in order 0,1,2,0,1,2; each rvalid_o bit follows its gnt_o bit by one cycle.
REQ-031 SHALL cover: port 1 requests with mgnt_i=0 for 4 cycles while port 0 asserts req_i in cycle 2 -> maddr_o stays at port 1's address; gnt_o=3'b010 when mgnt_i rises.
REQ-032 SHALL cover: MaxOutstanding=2, two grants with no mrvalid_i -> mreq_o=0 in cycle 3; one mrvalid_i -> mreq_o reasserts the next cycle; responses return in grant order.
REQ-033 SHALL cover: mrvalid_i pulse with an empty FIFO -> rvalid_o=0 and err_o=1 from the next cycle, held until rst_ni low.
REQ-034 SHALL cover: with TB_MEM_ARB_FIXED_PRIO_EN, req_i=3'b111 held -> port 2 granted every cycle; with req_i=3'b011 -> ports alternate 0,1.
REQ-035 SHALL cover: rst_ni asserted with occupancy 2 -> occupancy 0 and idle_o tracks req_i; a later mrvalid_i sets err_o.

Source files
------------

// File: rtl/tb_mem_arbiter.sv
// N-to-1 memory request arbiter with in-order response routing; TB_MEM_ARB_FIXED_PRIO_EN gives port NrPorts-1 absolute priority.
// Latency: request/grant and response/rvalid are combinational pass-through; bookkeeping updates on the next clk_i edge.
// Backpressure: mreq_o is withheld at MaxOutstanding; an ungranted selection stays locked until mgnt_i or req_i drop.
module tb_mem_arbiter #(
  parameter  int NrPorts        = 3,
  parameter  int AddrWidth      = 32,
  parameter  int DataWidth      = 32,
  parameter  int MaxOutstanding = 2,
  localparam int BeWidth        = DataWidth / 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrPorts-1:0]                 req_i,
  input  logic [NrPorts-1:0]                 we_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NrPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NrPorts-1:0]                 gnt_o,
  output logic [NrPorts-1:0]                 rvalid_o,
  output logic [DataWidth-1:0]               rdata_o,
  output logic                               mreq_o,
  output logic                               mwe_o,
  output logic [AddrWidth-1:0]               maddr_o,
  output logic [DataWidth-1:0]               mwdata_o,
  output logic [BeWidth-1:0]                 mbe_o,
  input  logic                               mgnt_i,
  input  logic                               mrvalid_i,
  input  logic [DataWidth-1:0]               mrdata_i,
  output logic                               idle_o,
  output logic                               err_o
);

  localparam int PortW = $clog2(NrPorts);
  localparam int OccW  = $clog2(MaxOutstanding + 1);
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [OccW-1:0]  OccMax   = OccW'(MaxOutstanding);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(MaxOutstanding - 1);
  localparam logic [PortW-1:0] PortLast = PortW'(NrPorts - 1);

  logic [PortW-1:0]   last_granted;
  logic [PortW-1:0]   lock_port;
  logic               lock_vld;
  logic [PortW-1:0]   sel_port;
  logic               sel_found;
  logic [PortW-1:0]   cand;
  logic [NrPorts-1:0] rr_req;

  logic [OccW-1:0]    occ;
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [PortW-1:0]   id_mem [MaxOutstanding];
  logic [PortW-1:0]   head_id;

  logic full;
  logic empty;
  logic mreq;
  logic push;
  logic pop;

  // Selection: locked port first, then (optionally) the debug port, then round-robin.
  always_comb begin
    rr_req = req_i;
`ifdef TB_MEM_ARB_FIXED_PRIO_EN
    rr_req[NrPorts-1] = 1'b0;
`endif
    sel_found = 1'b0;
    sel_port  = '0;
    cand      = '0;
    for (int i = 1; i <= NrPorts; i++) begin
      cand = PortW'((int'(last_granted) + i) % NrPorts);
      if (!sel_found && rr_req[cand]) begin
        sel_found = 1'b1;
        sel_port  = cand;
      end
    end
`ifdef TB_MEM_ARB_FIXED_PRIO_EN
    if (req_i[NrPorts-1]) begin
      sel_found = 1'b1;
      sel_port  = PortLast;
    end
`endif
    if (lock_vld && req_i[lock_port]) begin
      sel_found = 1'b1;
      sel_port  = lock_port;
    end
  end

  assign full    = (occ == OccMax);
  assign empty   = (occ == '0);
  assign mreq    = rst_ni && sel_found && !full;
  assign push    = mreq && mgnt_i;
  assign pop     = mrvalid_i && !empty;
  assign head_id = id_mem[rd_ptr];

  assign mreq_o   = mreq;
  assign mwe_o    = mreq ? we_i[sel_port]    : 1'b0;
  assign maddr_o  = mreq ? addr_i[sel_port]  : '0;
  assign mwdata_o = mreq ? wdata_i[sel_port] : '0;
  assign mbe_o    = mreq ? be_i[sel_port]    : '0;
  assign gnt_o    = push ? (NrPorts'(1) << sel_port) : '0;
  assign rvalid_o = pop  ? (NrPorts'(1) << head_id)  : '0;
  assign rdata_o  = pop  ? mrdata_i : '0;
  assign idle_o   = empty && (req_i == '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr] <= sel_port;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_granted <= PortLast;
      lock_vld     <= 1'b0;
      lock_port    <= '0;
      err_o        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
`ifdef TB_MEM_ARB_FIXED_PRIO_EN
        // Debug-port grants leave the round-robin pointer of the other ports alone.
        if (sel_port != PortLast) begin
          last_granted <= sel_port;
        end
`else
        last_granted <= sel_port;
`endif
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      lock_vld  <= mreq && !mgnt_i;
      lock_port <= sel_port;
      if (mrvalid_i && empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Self-checking bench for tb_mem_arbiter: vector table plus scoreboarded multi-cycle sequences.
module tb_tb_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NP-1:0]          req, we;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][DW-1:0]  wdata;
  logic [NP-1:0][BW-1:0]  be;
  logic [NP-1:0]          gnt, rvalid;
  logic [DW-1:0]          rdata;
  logic                   mreq, mwe, mgnt, mrvalid, idle, err;
  logic [AW-1:0]          maddr;
  logic [DW-1:0]          mwdata, mrdata;
  logic [BW-1:0]          mbe;

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];

  always #5 clk = ~clk;

  tb_mem_arbiter #(.NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mreq_o(mreq), .mwe_o(mwe),
    .maddr_o(maddr), .mwdata_o(mwdata), .mbe_o(mbe), .mgnt_i(mgnt), .mrvalid_i(mrvalid),
    .mrdata_i(mrdata), .idle_o(idle), .err_o(err)
  );

  typedef struct {
    logic [NP-1:0] req;
    logic          mgnt;
    logic          mrvalid;
    logic          exp_mreq;
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] exp_rvalid;
    int            exp_port;
    logic          exp_idle;
  } vec_t;

  function automatic vec_t mk(input logic [NP-1:0] r, input logic g, input logic v, input logic em,
                              input logic [NP-1:0] eg, input logic [NP-1:0] ev, input int ep,
                              input logic ei);
    vec_t t;
    t.req = r; t.mgnt = g; t.mrvalid = v; t.exp_mreq = em;
    t.exp_gnt = eg; t.exp_rvalid = ev; t.exp_port = ep; t.exp_idle = ei;
    return t;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int k);
    return 32'hA000_0000 | 32'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_sel(input string name, input int port);
    if (port < 0) begin
      check({name, " maddr"}, maddr, 0);
      check({name, " mwdata"}, mwdata, 0);
    end else begin
      check({name, " maddr"}, maddr, addr_of(port));
      check({name, " mwdata"}, mwdata, wdata_of(port));
      check({name, " mbe"}, mbe, 4'b0001 << port);
      check({name, " mwe"}, mwe, (port == 1) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic cycle(input logic [NP-1:0] r, input logic g, input logic v, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    req = r; mgnt = g; mrvalid = v; mrdata = d;
    @(negedge clk);
  endtask

  task automatic grant_cycle(input logic [NP-1:0] r, input int port, input string tag);
    cycle(r, 1'b1, 1'b0, '0);
    sb.push_back(port);
    check({tag, " gnt"}, gnt, 3'b001 << port);
    check_sel(tag, port);
  endtask

  task automatic respond(input logic [NP-1:0] r, input logic g, input logic [DW-1:0] d, input string tag);
    int exp_id;
    cycle(r, g, 1'b1, d);
    if (sb.size() == 0) begin
      check({tag, " rvalid-empty"}, rvalid, 0);
      check({tag, " rdata-empty"}, rdata, 0);
    end else begin
      exp_id = sb.pop_front();
      check({tag, " rvalid"}, rvalid, 3'b001 << exp_id);
      check({tag, " rdata"}, rdata, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [NP-1:0] exp_rv;
    string tag;
`ifdef TB_MEM_ARB_FIXED_PRIO_EN
    vt[0] = mk(3'b111, 1, 0, 1, 3'b100, 3'b000,  2, 0);
    vt[1] = mk(3'b111, 1, 1, 1, 3'b100, 3'b100,  2, 0);
    vt[2] = mk(3'b111, 1, 1, 1, 3'b100, 3'b100,  2, 0);
    vt[3] = mk(3'b011, 1, 1, 1, 3'b001, 3'b100,  0, 0);
    vt[4] = mk(3'b011, 1, 1, 1, 3'b010, 3'b001,  1, 0);
    vt[5] = mk(3'b011, 1, 1, 1, 3'b001, 3'b010,  0, 0);
    vt[6] = mk(3'b000, 0, 1, 0, 3'b000, 3'b001, -1, 0);
    vt[7] = mk(3'b000, 0, 0, 0, 3'b000, 3'b000, -1, 1);
`else
    vt[0] = mk(3'b111, 1, 0, 1, 3'b001, 3'b000,  0, 0);
    vt[1] = mk(3'b111, 1, 1, 1, 3'b010, 3'b001,  1, 0);
    vt[2] = mk(3'b111, 1, 1, 1, 3'b100, 3'b010,  2, 0);
    vt[3] = mk(3'b111, 1, 1, 1, 3'b001, 3'b100,  0, 0);
    vt[4] = mk(3'b111, 1, 1, 1, 3'b010, 3'b001,  1, 0);
    vt[5] = mk(3'b111, 1, 1, 1, 3'b100, 3'b010,  2, 0);
    vt[6] = mk(3'b000, 0, 1, 0, 3'b000, 3'b100, -1, 0);
    vt[7] = mk(3'b000, 0, 0, 0, 3'b000, 3'b000, -1, 1);
`endif
    we = 3'b010;
    for (int k = 0; k < NP; k++) begin
      addr[k]  = addr_of(k);
      wdata[k] = wdata_of(k);
      be[k]    = 4'b0001 << k;
    end

    // Reset: outputs quiet even with live inputs, idle follows req.
    rst_n = 1'b0; req = 3'b101; mgnt = 1'b1; mrvalid = 1'b1; mrdata = 32'hDEAD_BEEF;
    #7;
    check("rst mreq", mreq, 0);
    check("rst gnt", gnt, 0);
    check("rst rvalid", rvalid, 0);
    check("rst rdata", rdata, 0);
    check("rst maddr", maddr, 0);
    check("rst err", err, 0);
    check("rst idle-busy", idle, 0);
    req = '0;
    #1;
    check("rst idle", idle, 1);
    mgnt = 1'b0; mrvalid = 1'b0; mrdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cycle(vt[i].req, vt[i].mgnt, vt[i].mrvalid, 32'hD000_0000 + 32'(i));
      tag = $sformatf("v%0d", i);
      exp_rv = vt[i].exp_rvalid;
      check({tag, " mreq"}, mreq, vt[i].exp_mreq);
      check({tag, " gnt"}, gnt, vt[i].exp_gnt);
      check({tag, " rvalid"}, rvalid, exp_rv);
      check({tag, " rdata"}, rdata, (exp_rv != 0) ? 32'hD000_0000 + 32'(i) : 32'h0);
      check({tag, " idle"}, idle, vt[i].exp_idle);
      check({tag, " err"}, err, 0);
      check_sel(tag, vt[i].exp_port);
    end

    // Locked selection survives a competing request until granted.
    cycle(3'b010, 1'b0, 1'b0, '0);
    check("lock c1 mreq", mreq, 1);
    check("lock c1 gnt", gnt, 0);
    check_sel("lock c1", 1);
    for (int c = 2; c <= 4; c++) begin
      cycle(3'b011, 1'b0, 1'b0, '0);
      check($sformatf("lock c%0d gnt", c), gnt, 0);
      check_sel($sformatf("lock c%0d", c), 1);
    end
    grant_cycle(3'b011, 1, "lock grant");
    respond(3'b000, 1'b0, 32'h1111_0001, "lock resp");

    // Outstanding limit: third request held back, responses in grant order.
    grant_cycle(3'b011, 0, "full g0");
    grant_cycle(3'b011, 1, "full g1");
    cycle(3'b011, 1'b1, 1'b0, '0);
    check("full mreq", mreq, 0);
    check("full gnt", gnt, 0);
    check_sel("full", -1);
    respond(3'b011, 1'b1, 32'h2222_0000, "full resp0");
    check("full pop mreq", mreq, 0);
    check("full pop gnt", gnt, 0);
    cycle(3'b011, 1'b0, 1'b0, '0);
    check("reassert mreq", mreq, 1);
    check_sel("reassert", 0);
    respond(3'b000, 1'b0, 32'h2222_0001, "full resp1");
    check("drain idle-busy", idle, 0);
    cycle(3'b000, 1'b0, 1'b0, '0);
    check("drain idle", idle, 1);

    // Reset with two transactions in flight.
    grant_cycle(3'b011, 0, "mid g0");
    grant_cycle(3'b011, 1, "mid g1");
    cycle(3'b011, 1'b0, 1'b0, '0);
    check("mid full mreq", mreq, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid rst mreq", mreq, 0);
    check("mid rst maddr", maddr, 0);
    check("mid rst idle-busy", idle, 0);
    req = '0; mrvalid = 1'b1;
    #1;
    check("mid rst idle", idle, 1);
    check("mid rst rvalid", rvalid, 0);
    mrvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("post rst idle", idle, 1);
    check("post rst err", err, 0);

    // Stale response: ignored, err sticky from the next edge.
    respond(3'b000, 1'b0, 32'h3333_0000, "stale");
    check("stale err same cycle", err, 0);
    for (int c = 0; c < 4; c++) begin
      cycle(3'b000, 1'b0, 1'b0, '0);
      check($sformatf("err held %0d", c), err, 1);
    end
`ifdef TB_MEM_ARB_FIXED_PRIO_EN
    grant_cycle(3'b111, 2, "post rst first");
`else
    grant_cycle(3'b111, 0, "post rst first");
`endif
    respond(3'b000, 1'b0, 32'h4444_0000, "post rst resp");
    check("err still held", err, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("err cleared by rst", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("err after release", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
